fifo_rd_packer: RTL and testbench

Read-side consumer of the async FIFO, clocked in the read domain. Pops DSIZE-bit entries from the FIFO head through the `rempty`/`rinc`/`rdata` interface and packs LANES consecutive entries into one wide word. Each word is presented on a valid/ready output stream with a per-lane keep mask. Partial words are emitted on an explicit flush, and optionally on an idle timeout.

---
 rtl/fifo_rd_packer.sv | 149 ++++++++++++++
 tb/tb_fifo_rd_packer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer
//   Read-side consumer of an async FIFO, running entirely in the read clock
//   domain. Pops DSIZE-bit entries from the FIFO head and packs LANES
//   consecutive entries into one wide word. The word leaves on a
//   valid/ready stream together with a contiguous per-lane keep mask.
//   Partial words leave on an explicit flush request. When the macro
//   RD_PACKER_TIMEOUT_EN is defined, they also leave after TIMEOUT idle
//   cycles.
//
// Parameters
//   DSIZE    FIFO entry width (must match the FIFO)
//   LANES    entries per output word (>= 2)
//   TIMEOUT  idle cycles before a partial word is auto-flushed (>= 1);
//            only used with RD_PACKER_TIMEOUT_EN
//
// Ports
//   rclk     in   read-domain clock, all state on the rising edge
//   rrst     in   synchronous reset, active-high
//   rempty   in   FIFO empty flag
//   rdata    in   FIFO head data, valid whenever rempty = 0
//   rinc     out  FIFO pop strobe (combinational)
//   flush    in   emit the collector contents if it is non-empty
//   m_data   out  packed word, lane 0 in the low DSIZE bits
//   m_keep   out  lane-valid mask, set contiguously from lane 0
//   m_valid  out  output word valid
//   m_ready  in   downstream accept
module fifo_rd_packer #(
  parameter int DSIZE   = 8,
  parameter int LANES   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                   rclk,
  input  logic                   rrst,
  input  logic                   rempty,
  input  logic [DSIZE-1:0]       rdata,
  output logic                   rinc,
  input  logic                   flush,
  output logic [DSIZE*LANES-1:0] m_data,
  output logic [LANES-1:0]       m_keep,
  output logic                   m_valid,
  input  logic                   m_ready
);

  localparam int CW = $clog2(LANES + 1);

  // Catch illegal parameterisations at elaboration time.
  if (LANES < 2) begin : g_bad_lanes
    $error("fifo_rd_packer: LANES must be at least 2");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("fifo_rd_packer: TIMEOUT must be at least 1");
  end

  logic [CW-1:0]          cnt_q, cnt_d;
  logic [DSIZE*LANES-1:0] data_q;
  logic [LANES-1:0]       keep_q;
  logic                   valid_q;

  logic [DSIZE*LANES-1:0] word_d;
  logic [LANES-1:0]       keep_d;
  logic                   out_free;
  logic                   full;
  logic                   xfer;
  logic                   pop;
  logic                   tmo_hit;

  assign out_free = !valid_q || m_ready;
  assign full     = (cnt_q == CW'(LANES));
  assign xfer     = out_free && (full || ((cnt_q != '0) && (flush || tmo_hit)));
  // A full collector may still pop when it empties into the output
  // register in the same cycle; the new entry starts the next word.
  assign pop      = !rrst && !rempty && (!full || xfer);
  assign rinc     = pop;

  // Collector lanes. While a word is moving out, a pop lands in lane 0.
  // Otherwise it lands in lane cnt.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [DSIZE-1:0] lane_q;

    always_ff @(posedge rclk) begin
      if (rrst) begin
        lane_q <= '0;
      end else if (pop && ((xfer && (gi == 0)) || (!xfer && (cnt_q == CW'(gi))))) begin
        lane_q <= rdata;
      end
    end

    // Lanes at or above cnt go out as zero with keep cleared.
    assign keep_d[gi]                 = (CW'(gi) < cnt_q);
    assign word_d[gi*DSIZE +: DSIZE]  = keep_d[gi] ? lane_q : '0;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (xfer) begin
      cnt_d = pop ? CW'(1) : '0;
    end else if (pop) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Output register: loads on xfer, otherwise drops valid on acceptance.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      data_q  <= '0;
      keep_q  <= '0;
      valid_q <= 1'b0;
    end else if (xfer) begin
      data_q  <= word_d;
      keep_q  <= keep_d;
      valid_q <= 1'b1;
    end else if (m_ready) begin
      valid_q <= 1'b0;
    end
  end

`ifdef RD_PACKER_TIMEOUT_EN
  localparam int IW = $clog2(TIMEOUT + 1);

  logic [IW-1:0] idle_q;

  assign tmo_hit = (idle_q == IW'(TIMEOUT));

  // Counts cycles in which a partial word sits without new entries.
  // Saturates at TIMEOUT so the request persists while the output is blocked.
  always_ff @(posedge rclk) begin
    if (rrst || pop || xfer) begin
      idle_q <= '0;
    end else if ((cnt_q != '0) && !tmo_hit) begin
      idle_q <= idle_q + IW'(1);
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  assign m_data  = data_q;
  assign m_keep  = keep_q;
  assign m_valid = valid_q;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// tb_fifo_rd_packer
//   Directed bench for fifo_rd_packer with DSIZE=8, LANES=4, TIMEOUT=16.
//   A simple FIFO model feeds the DUT. Each test queues the words it
//   expects as literals. A per-cycle compare process checks several things:
//   every accepted word against that queue, every accepted word against
//   the stream of entries actually popped, held words for stability, and
//   rinc against rempty and rrst.
module tb_fifo_rd_packer;

  localparam int DSIZE   = 8;
  localparam int LANES   = 4;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rrst;
  logic        rempty;
  logic [7:0]  rdata;
  logic        rinc;
  logic        flush;
  logic [31:0] m_data;
  logic [3:0]  m_keep;
  logic        m_valid;
  logic        m_ready;

  fifo_rd_packer #(
    .DSIZE  (DSIZE),
    .LANES  (LANES),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .rclk   (clk),
    .rrst   (rrst),
    .rempty (rempty),
    .rdata  (rdata),
    .rinc   (rinc),
    .flush  (flush),
    .m_data (m_data),
    .m_keep (m_keep),
    .m_valid(m_valid),
    .m_ready(m_ready)
  );

  // FIFO model: the head advances at every clock edge with rinc = 1.
  logic [7:0] fifo_mem [0:255];
  logic [7:0] wr_ptr = 8'd0;
  logic [7:0] rd_ptr = 8'd0;
  assign rempty = (wr_ptr == rd_ptr);
  assign rdata  = fifo_mem[rd_ptr];

  int cyc = 0;
  bit rst_prev = 1'b0;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_prev <= rrst;
    if (rinc) rd_ptr <= rd_ptr + 8'd1;
  end

  int checks = 0;
  int passed = 0;

  task automatic check(input bit ok, input string name,
                       input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (ok) passed++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
  endtask

  // Scoreboard state
  logic [31:0] exp_data_q [$];
  logic [3:0]  exp_keep_q [$];
  logic [7:0]  popped_q   [$];
  int          pop_count     = 0;
  int          first_pop_cyc = 0;
  int          last_pop_cyc  = 0;
  int          valid_rise_cyc = 0;
  int          word_count    = 0;
  bit          hold_prev     = 1'b0;
  bit          mv_prev       = 1'b0;
  logic [31:0] hold_data;
  logic [3:0]  hold_keep;

  always @(negedge clk) begin
    if (rrst) begin
      check(rinc == 1'b0, "rinc_in_reset", 32'(rinc), 32'd0);
      popped_q.delete();  // a reset discards everything popped so far
    end
    if (rst_prev) begin
      check(m_valid == 1'b0, "reset_m_valid", 32'(m_valid), 32'd0);
      check(m_keep == 4'h0, "reset_m_keep", 32'(m_keep), 32'd0);
      check(m_data == 32'h0, "reset_m_data", m_data, 32'd0);
    end
    if (rempty) check(rinc == 1'b0, "rinc_when_empty", 32'(rinc), 32'd0);

    if (hold_prev && !rst_prev) begin
      check(m_valid == 1'b1, "hold_valid", 32'(m_valid), 32'd1);
      check(m_data == hold_data, "hold_data", m_data, hold_data);
      check(m_keep == hold_keep, "hold_keep", 32'(m_keep), 32'(hold_keep));
    end
    hold_prev = m_valid && !m_ready && !rrst;
    hold_data = m_data;
    hold_keep = m_keep;

    if (m_valid && !mv_prev) valid_rise_cyc = cyc;
    mv_prev = m_valid;

    if (rinc) begin
      if (pop_count == 0) first_pop_cyc = cyc;
      last_pop_cyc = cyc;
      pop_count++;
      popped_q.push_back(rdata);
    end

    if (m_valid && m_ready && !rrst) begin
      word_count++;
      if (exp_data_q.size() == 0) begin
        check(1'b0, "unexpected_word", m_data, 32'd0);
      end else begin
        logic [31:0] ed;
        logic [3:0]  ek;
        logic [31:0] model;
        int          k;
        ed = exp_data_q.pop_front();
        ek = exp_keep_q.pop_front();
        check(m_data == ed, "word_data", m_data, ed);
        check(m_keep == ek, "word_keep", 32'(m_keep), 32'(ek));
        // The word must equal the next popcount(keep) popped entries,
        // with lane 0 holding the oldest entry.
        k = 0;
        for (int i = 0; i < LANES; i++) if (ek[i]) k++;
        model = 32'h0;
        for (int i = 0; i < k; i++) begin
          if (popped_q.size() == 0) check(1'b0, "stream_underrun", 32'(i), 32'(k));
          else model[i*8 +: 8] = popped_q.pop_front();
        end
        check(m_data == model, "stream_order", m_data, model);
      end
    end
  end

  task automatic push(input logic [7:0] v);
    fifo_mem[wr_ptr] = v;
    wr_ptr = wr_ptr + 8'd1;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_word(input logic [31:0] d, input logic [3:0] k);
    exp_data_q.push_back(d);
    exp_keep_q.push_back(k);
  endtask

  task automatic wait_drain(input string name, input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      if (rempty && exp_data_q.size() == 0 && !m_valid) done = 1'b1;
      else tick(1);
    end
    check(done, name, 32'(exp_data_q.size()), 32'd0);
  endtask

  int wc0;

  initial begin
    rrst    = 1'b1;
    flush   = 1'b0;
    m_ready = 1'b1;

    // Reset held with a non-empty FIFO: nothing may be popped.
    tick(1);
    for (int v = 0; v < 16; v++) push(8'(v));
    tick(3);
    check(rinc == 1'b0, "reset_rinc_nonempty", 32'(rinc), 32'd0);
    check(m_valid == 1'b0, "reset_valid_hold", 32'(m_valid), 32'd0);
    check(m_keep == 4'h0, "reset_keep_hold", 32'(m_keep), 32'd0);

    // Streaming with the sink always ready.
    expect_word(32'h03020100, 4'hF);
    expect_word(32'h07060504, 4'hF);
    expect_word(32'h0B0A0908, 4'hF);
    expect_word(32'h0F0E0D0C, 4'hF);
    pop_count = 0;
    rrst = 1'b0;
    wait_drain("stream_drain", 60);
    check(pop_count == 16, "stream_pop_count", 32'(pop_count), 32'd16);
    check(last_pop_cyc - first_pop_cyc == 15, "stream_pops_consecutive",
          32'(last_pop_cyc - first_pop_cyc), 32'd15);
    tick(5);
    check(pop_count == 16, "no_pop_after_empty", 32'(pop_count), 32'd16);

    // Backpressure: one word in the output register, one in the collector.
    m_ready = 1'b0;
    pop_count = 0;
    for (int v = 0; v < 16; v++) push(8'(v));
    expect_word(32'h03020100, 4'hF);
    expect_word(32'h07060504, 4'hF);
    expect_word(32'h0B0A0908, 4'hF);
    expect_word(32'h0F0E0D0C, 4'hF);
    tick(20);
    check(pop_count == 8, "bp_pop_count", 32'(pop_count), 32'd8);
    check(m_valid == 1'b1, "bp_valid", 32'(m_valid), 32'd1);
    check(m_data == 32'h03020100, "bp_held_word", m_data, 32'h03020100);
    m_ready = 1'b1;
    wait_drain("bp_drain", 60);
    check(pop_count == 16, "bp_total_pops", 32'(pop_count), 32'd16);

    // Partial word via flush, then flush on an empty collector.
    push(8'hA1); push(8'hB2); push(8'hC3);
    expect_word(32'h00C3B2A1, 4'b0111);
    tick(5);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    wait_drain("flush_drain", 20);
    wc0 = word_count;
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    tick(10);
    check(word_count == wc0, "flush_empty_no_word", 32'(word_count), 32'(wc0));

    // Idle partial word.
    push(8'h55); push(8'h66);
    expect_word(32'h00006655, 4'b0011);
`ifdef RD_PACKER_TIMEOUT_EN
    wait_drain("timeout_drain", 60);
    // The last pop is sampled one negedge before its edge, so valid rises
    // TIMEOUT+1 edges later, which is TIMEOUT+2 sample points.
    check(valid_rise_cyc - last_pop_cyc == TIMEOUT + 2, "timeout_latency",
          32'(valid_rise_cyc - last_pop_cyc), 32'(TIMEOUT + 2));
`else
    wc0 = word_count;
    tick(100);
    check(word_count == wc0 && !m_valid, "no_timeout_word",
          32'(word_count), 32'(wc0));
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    wait_drain("idle_flush_drain", 20);
`endif

    // Reset mid-operation discards the partial collector.
    push(8'h20); push(8'h21);
    tick(4);
    rrst = 1'b1;
    tick(1);
    rrst = 1'b0;
    wc0 = word_count;
    for (int v = 16; v < 20; v++) push(8'(v));
    expect_word(32'h13121110, 4'hF);
    wait_drain("reset_mid_drain", 30);
    tick(3);
    check(word_count == wc0 + 1, "reset_single_word", 32'(word_count), 32'(wc0 + 1));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
